otter_fetch_queue: RTL and testbench

- Decoupled instruction-fetch front end for the pipelined OTTER.
- Owns the fetch PC and issues word reads to instruction memory port 1.
- Buffers returned instructions with their PCs in a small FIFO, presented to decode via valid/ready.
- Decode stall (load-use) becomes backpressure instead of a PC write-enable; branch/jump redirects from execute flush the queue.

---
 rtl/otter_fetch_queue.sv | 115 +++++++++++
 tb/tb_otter_fetch_queue.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_fetch_queue.sv
// Decoupled OTTER instruction-fetch front end: owns the fetch PC, issues word
// reads to memory port 1 and queues {pc, instruction} pairs for decode.
module otter_fetch_queue #(
   parameter int unsigned DEPTH     = 4,
   parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        REDIRECT,
   input  logic [31:0] REDIRECT_PC,
   output logic [31:0] MEM_ADDR,
   output logic        MEM_READ,
   input  logic        MEM_READY,
   input  logic [31:0] MEM_DOUT,
   output logic        ID_VALID,
   input  logic        ID_READY,
   output logic [31:0] ID_IR,
   output logic [31:0] ID_PC
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;
   localparam int unsigned OW = CW + 1;

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   req_pc_q, req_pc_d;
   logic          inflight_q, inflight_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [31:0]   ir_mem_q [DEPTH];
   logic [31:0]   ir_mem_d [DEPTH];
   logic [31:0]   pc_mem_q [DEPTH];
   logic [31:0]   pc_mem_d [DEPTH];

   logic [OW-1:0] occupancy_c;
   logic          accept_c;
   logic          push_c;
   logic          pop_c;
   logic          id_valid_c;

   // Queued plus in-flight entries bound issue; a same-cycle pop earns no credit.
   assign occupancy_c = OW'(count_q) + OW'(inflight_q);
   assign MEM_READ    = !RESET && !REDIRECT && (occupancy_c < OW'(DEPTH));
   assign MEM_ADDR    = RESET ? RESET_VEC : fetch_pc_q;
   assign accept_c    = MEM_READ && MEM_READY;

   assign id_valid_c  = !RESET && (count_q != '0);
   assign ID_VALID    = id_valid_c;
   assign ID_IR       = RESET ? 32'h0 : ir_mem_q[rd_ptr_q];
   assign ID_PC       = RESET ? 32'h0 : pc_mem_q[rd_ptr_q];

   assign push_c      = inflight_q && !REDIRECT;
   assign pop_c       = id_valid_c && ID_READY && !REDIRECT;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      inflight_d = inflight_q;
      count_d    = count_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      ir_mem_d   = ir_mem_q;
      pc_mem_d   = pc_mem_q;

      if (REDIRECT) begin
         // Flush everything, including a response landing this cycle.
         fetch_pc_d = REDIRECT_PC & ~32'h3;
         inflight_d = 1'b0;
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
      end else begin
         inflight_d = accept_c;
         if (accept_c) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (push_c) begin
            ir_mem_d[wr_ptr_q] = MEM_DOUT;
            pc_mem_d[wr_ptr_q] = req_pc_q;
            wr_ptr_d           = wr_ptr_q + PW'(1);
         end
         if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push_c) - CW'(pop_c);
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         fetch_pc_q <= RESET_VEC;
         req_pc_q   <= 32'h0;
         inflight_q <= 1'b0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            ir_mem_q[i] <= 32'h0;
            pc_mem_q[i] <= 32'h0;
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         ir_mem_q   <= ir_mem_d;
         pc_mem_q   <= pc_mem_d;
      end
   end

endmodule

// File: tb/tb_otter_fetch_queue.sv
// Bench for otter_fetch_queue: directed scenarios plus randomized traffic
// checked against a transaction-level queue model.
module tb_otter_fetch_queue;

   localparam int unsigned DEPTH     = 4;
   localparam logic [31:0] RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] KEY       = 32'hA5A5_0000;

   logic        CLK = 1'b0;
   logic        RESET, REDIRECT, MEM_READY, ID_READY;
   logic [31:0] REDIRECT_PC, MEM_DOUT;
   logic [31:0] MEM_ADDR, ID_IR, ID_PC;
   logic        MEM_READ, ID_VALID;

   otter_fetch_queue #(.DEPTH(DEPTH), .RESET_VEC(RESET_VEC)) dut (
      .CLK(CLK), .RESET(RESET), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
      .MEM_ADDR(MEM_ADDR), .MEM_READ(MEM_READ), .MEM_READY(MEM_READY),
      .MEM_DOUT(MEM_DOUT), .ID_VALID(ID_VALID), .ID_READY(ID_READY),
      .ID_IR(ID_IR), .ID_PC(ID_PC)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: queue of delivered instructions plus one outstanding read.
   typedef struct packed { logic [31:0] pc; logic [31:0] ir; } ent_t;
   ent_t        m_q[$];
   logic [31:0] m_fpc = RESET_VEC;
   logic [31:0] m_ipc = 32'h0;
   bit          m_infl = 1'b0;

   logic        e_read, e_valid;
   logic [31:0] e_addr, e_pc, e_ir;

   task automatic set_in(input logic rst, input logic redir, input logic [31:0] rpc,
                         input logic mrdy, input logic irdy);
      RESET = rst; REDIRECT = redir; REDIRECT_PC = rpc; MEM_READY = mrdy; ID_READY = irdy;
      #1;
      e_read  = !rst && !redir && ((m_q.size() + int'(m_infl)) < int'(DEPTH));
      e_addr  = rst ? RESET_VEC : m_fpc;
      e_valid = !rst && (m_q.size() != 0);
      e_pc    = e_valid ? m_q[0].pc : 32'h0;
      e_ir    = e_valid ? m_q[0].ir : 32'h0;
   endtask

   // Advance one clock: update model, then play memory (data 1 cycle after accept).
   task automatic tick();
      logic        acc;
      logic [31:0] a;
      acc = MEM_READ && MEM_READY;
      a   = MEM_ADDR;
      @(posedge CLK);
      if (RESET) begin
         m_q.delete(); m_fpc = RESET_VEC; m_infl = 1'b0;
      end else if (REDIRECT) begin
         m_q.delete(); m_fpc = REDIRECT_PC & ~32'h3; m_infl = 1'b0;
      end else begin
         if (e_valid && ID_READY) void'(m_q.pop_front());
         if (m_infl) m_q.push_back('{pc: m_ipc, ir: m_ipc ^ KEY});
         m_infl = e_read && MEM_READY;
         if (m_infl) begin
            m_ipc = m_fpc;
            m_fpc = m_fpc + 32'd4;
         end
      end
      #1;
      MEM_DOUT = acc ? (a ^ KEY) : $urandom;
   endtask

   task automatic do_reset();
      for (int i = 0; i < 2; i++) begin
         set_in(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
         tick();
      end
   endtask

   task automatic test_reset();
      set_in(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      tick();
      set_in(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      n_checks++; if (MEM_READ !== 1'b0) $display("FAIL reset_mem_read: got %b want 0", MEM_READ); else n_pass++;
      n_checks++; if (MEM_ADDR !== RESET_VEC) $display("FAIL reset_mem_addr: got %h want %h", MEM_ADDR, RESET_VEC); else n_pass++;
      n_checks++; if (ID_VALID !== 1'b0) $display("FAIL reset_id_valid: got %b want 0", ID_VALID); else n_pass++;
      n_checks++; if ({ID_IR, ID_PC} !== 64'h0) $display("FAIL reset_id_ir_pc: got %h/%h want 0/0", ID_IR, ID_PC); else n_pass++;
      tick();
   endtask

   task automatic test_stream();
      logic [31:0] pc;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
         n_checks++; if ({MEM_READ, MEM_ADDR} !== {1'b1, 32'(4 * i)}) $display("FAIL stream_addr[%0d]: got %b/%h want 1/%h", i, MEM_READ, MEM_ADDR, 32'(4 * i)); else n_pass++;
         if (i < 2) begin
            n_checks++; if (ID_VALID !== 1'b0) $display("FAIL stream_latency[%0d]: got valid %b want 0", i, ID_VALID); else n_pass++;
         end else begin
            pc = 32'(4 * (i - 2));
            n_checks++; if ({ID_VALID, ID_PC, ID_IR} !== {1'b1, pc, pc ^ KEY}) $display("FAIL stream_head[%0d]: got %b/%h/%h want 1/%h/%h", i, ID_VALID, ID_PC, ID_IR, pc, pc ^ KEY); else n_pass++;
         end
         tick();
      end
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 0; i < 7; i++) begin
         set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
         n_checks++; if (MEM_READ !== (i < 4)) $display("FAIL fill_read[%0d]: got %b want %b", i, MEM_READ, (i < 4)); else n_pass++;
         if (i >= 2) begin
            n_checks++; if ({ID_VALID, ID_PC} !== {1'b1, 32'h0}) $display("FAIL fill_head[%0d]: got %b/%h want 1/0", i, ID_VALID, ID_PC); else n_pass++;
         end
         tick();
      end
      set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      n_checks++; if (MEM_READ !== 1'b0) $display("FAIL fill_no_pop_credit: got %b want 0", MEM_READ); else n_pass++;
      tick();
      set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      n_checks++; if ({MEM_READ, MEM_ADDR, ID_PC} !== {1'b1, 32'h10, 32'h4}) $display("FAIL fill_resume: got %b/%h/%h want 1/00000010/00000004", MEM_READ, MEM_ADDR, ID_PC); else n_pass++;
      tick();
   endtask

   task automatic test_redirect_full();
      logic [31:0] want;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
         tick();
      end
      set_in(1'b0, 1'b1, 32'h103, 1'b1, 1'b1);
      n_checks++; if (MEM_READ !== 1'b0) $display("FAIL redir_read: got %b want 0", MEM_READ); else n_pass++;
      tick();
      set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      n_checks++; if ({ID_VALID, MEM_READ, MEM_ADDR} !== {1'b0, 1'b1, 32'h100}) $display("FAIL redir_next: got %b/%b/%h want 0/1/00000100", ID_VALID, MEM_READ, MEM_ADDR); else n_pass++;
      tick();
      set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      n_checks++; if (ID_VALID !== 1'b0) $display("FAIL redir_gap: got %b want 0", ID_VALID); else n_pass++;
      tick();
      want = 32'h100;
      for (int i = 0; i < 5; i++) begin
         set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
         n_checks++; if ({ID_VALID, ID_PC} !== {1'b1, want}) $display("FAIL redir_stream[%0d]: got %b/%h want 1/%h", i, ID_VALID, ID_PC, want); else n_pass++;
         want += 32'd4;
         tick();
      end
   endtask

   task automatic test_inflight_discard();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
         tick();
      end
      set_in(1'b0, 1'b1, 32'h40, 1'b1, 1'b1);
      tick();
      for (int i = 0; i < 6; i++) begin
         set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
         if (i == 2) begin
            n_checks++; if ({ID_VALID, ID_PC} !== {1'b1, 32'h40}) $display("FAIL discard_first: got %b/%h want 1/00000040", ID_VALID, ID_PC); else n_pass++;
         end else if (i < 2) begin
            n_checks++; if (ID_VALID !== 1'b0) $display("FAIL discard_empty[%0d]: got %b want 0", i, ID_VALID); else n_pass++;
         end else begin
            n_checks++; if (ID_VALID && ID_PC == 32'h8) $display("FAIL discard_stale[%0d]: got pc %h want not 00000008", i, ID_PC); else n_pass++;
         end
         tick();
      end
   endtask

   task automatic test_mem_stall();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
         n_checks++; if ({MEM_READ, MEM_ADDR} !== {1'b1, 32'h14}) $display("FAIL stall_hold[%0d]: got %b/%h want 1/00000014", i, MEM_READ, MEM_ADDR); else n_pass++;
         if (i == 2) begin
            n_checks++; if (ID_VALID !== 1'b0) $display("FAIL stall_drain: got %b want 0", ID_VALID); else n_pass++;
         end
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
         if (i < 2) begin
            n_checks++; if (MEM_ADDR !== 32'(32'h14 + 4 * i)) $display("FAIL stall_resume_addr[%0d]: got %h want %h", i, MEM_ADDR, 32'(32'h14 + 4 * i)); else n_pass++;
         end else begin
            n_checks++; if ({ID_VALID, ID_PC} !== {1'b1, 32'(32'h14 + 4 * (i - 2))}) $display("FAIL stall_resume_pc[%0d]: got %b/%h want 1/%h", i, ID_VALID, ID_PC, 32'(32'h14 + 4 * (i - 2))); else n_pass++;
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         set_in(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
         n_checks++; if ({ID_VALID, MEM_READ} !== 2'b00) $display("FAIL midreset[%0d]: got valid/read %b/%b want 0/0", i, ID_VALID, MEM_READ); else n_pass++;
         tick();
      end
      set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      n_checks++; if ({MEM_READ, MEM_ADDR, ID_VALID} !== {1'b1, RESET_VEC, 1'b0}) $display("FAIL midreset_release: got %b/%h/%b want 1/%h/0", MEM_READ, MEM_ADDR, ID_VALID, RESET_VEC); else n_pass++;
      tick();
      set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      tick();
      set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      n_checks++; if ({ID_VALID, ID_PC} !== {1'b1, RESET_VEC}) $display("FAIL midreset_first: got %b/%h want 1/%h", ID_VALID, ID_PC, RESET_VEC); else n_pass++;
      tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         set_in($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0, $urandom,
                $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
         n_checks++; if ({MEM_READ, MEM_ADDR} !== {e_read, e_addr}) $display("FAIL rand_mem[%0d]: got %b/%h want %b/%h", i, MEM_READ, MEM_ADDR, e_read, e_addr); else n_pass++;
         n_checks++; if (ID_VALID !== e_valid) $display("FAIL rand_valid[%0d]: got %b want %b", i, ID_VALID, e_valid); else n_pass++;
         if (e_valid) begin
            n_checks++; if ({ID_PC, ID_IR} !== {e_pc, e_ir}) $display("FAIL rand_head[%0d]: got %h/%h want %h/%h", i, ID_PC, ID_IR, e_pc, e_ir); else n_pass++;
         end
         tick();
      end
   endtask

   initial begin
      RESET = 1'b1; REDIRECT = 1'b0; REDIRECT_PC = 32'h0;
      MEM_READY = 1'b1; ID_READY = 1'b1; MEM_DOUT = 32'h0;
      test_reset();
      test_stream();
      test_fill();
      test_redirect_full();
      test_inflight_discard();
      test_mem_stall();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
